// File: rtl/lu_cache_ctrl.sv
// lu_cache_ctrl: LU cache request controller with LRU replacement; optional hit/miss counters under LU_CACHE_STATS_EN
module lu_cache_ctrl #(
  parameter int CELLS     = 4,
  parameter int CELL_SIZE = 8,
  parameter int ADDR_SIZE = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wr,
  input  logic [ADDR_SIZE-1:0]       req_addr,
  input  logic [CELL_SIZE-1:0]       req_data,
  output logic [ADDR_SIZE-1:0]       check_addr,
  input  logic [CELLS-1:0]           cell_eq,
  input  logic [CELLS*CELL_SIZE-1:0] cell_rdata,
  output logic [CELLS-1:0]           cell_wen,
  output logic [ADDR_SIZE-1:0]       cell_waddr,
  output logic [CELL_SIZE-1:0]       cell_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_hit,
`ifdef LU_CACHE_STATS_EN
  output logic [15:0]                hit_cnt,
  output logic [15:0]                miss_cnt,
`endif
  output logic [CELL_SIZE-1:0]       rsp_data
);
  localparam int AGE_W = $clog2(CELLS);
  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;
  state_t               state_q, state_d;
  logic                 wr_q, wr_d, hit_q, hit_d;
  logic [CELL_SIZE-1:0] data_q, data_d;
  logic [ADDR_SIZE-1:0] check_addr_q, check_addr_d, cell_waddr_q, cell_waddr_d;
  logic [CELL_SIZE-1:0] cell_wdata_q, cell_wdata_d, rsp_data_q, rsp_data_d;
  logic [CELLS-1:0]     cell_wen_q, cell_wen_d, valid_q, valid_d, hitvec;
  logic                 rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
  logic [AGE_W-1:0]     sel_q, sel_d, idx, victim;
  logic [AGE_W-1:0]     age_q [CELLS];
  logic [AGE_W-1:0]     age_d [CELLS];
`ifdef LU_CACHE_STATS_EN
  logic [15:0]          hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
`endif
  // lowest-index hit wins on multi-hit; victim is the oldest cell
  always_comb begin
    hitvec = cell_eq & valid_q;
    idx    = '0;
    victim = '0;
    for (int i = CELLS-1; i >= 0; i--) begin
      if (hitvec[i]) idx = AGE_W'(i);
      if (age_q[i] == AGE_W'(CELLS-1)) victim = AGE_W'(i);
    end
  end
  // next-state, registered response/write outputs, LRU and valid maintenance
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    data_d       = data_q;
    hit_d        = hit_q;
    sel_d        = sel_q;
    check_addr_d = check_addr_q;
    cell_waddr_d = cell_waddr_q;
    cell_wdata_d = cell_wdata_q;
    cell_wen_d   = '0;
    rsp_valid_d  = 1'b0;
    rsp_hit_d    = 1'b0;
    rsp_data_d   = '0;
    valid_d      = valid_q;
    age_d        = age_q;
`ifdef LU_CACHE_STATS_EN
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        wr_d         = req_wr;
        data_d       = req_data;
        check_addr_d = req_addr;
        state_d      = LOOKUP;
      end
      LOOKUP: begin
        hit_d       = |hitvec;
        sel_d       = hit_d ? idx : victim;
        rsp_valid_d = 1'b1;
        rsp_hit_d   = hit_d;
        rsp_data_d  = (hit_d && !wr_q) ? cell_rdata[32'(idx)*CELL_SIZE +: CELL_SIZE] : '0;
        if (wr_q) begin
          cell_wen_d   = CELLS'(1) << sel_d;
          cell_waddr_d = check_addr_q;
          cell_wdata_d = data_q;
        end
`ifdef LU_CACHE_STATS_EN
        if (hit_d && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        if (!hit_d && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
`endif
        state_d = UPDATE;
      end
      UPDATE: begin
        if (hit_q || wr_q) begin
          for (int j = 0; j < CELLS; j++)
            if (age_q[j] < age_q[sel_q]) age_d[j] = age_q[j] + 1'b1;
          age_d[sel_q] = '0;
        end
        if (wr_q && !hit_q) valid_d[sel_q] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      data_q       <= '0;
      hit_q        <= 1'b0;
      sel_q        <= '0;
      check_addr_q <= '0;
      cell_waddr_q <= '0;
      cell_wdata_q <= '0;
      cell_wen_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_data_q   <= '0;
      valid_q      <= '0;
      for (int i = 0; i < CELLS; i++) age_q[i] <= AGE_W'(i);
`ifdef LU_CACHE_STATS_EN
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      data_q       <= data_d;
      hit_q        <= hit_d;
      sel_q        <= sel_d;
      check_addr_q <= check_addr_d;
      cell_waddr_q <= cell_waddr_d;
      cell_wdata_q <= cell_wdata_d;
      cell_wen_q   <= cell_wen_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_data_q   <= rsp_data_d;
      valid_q      <= valid_d;
      age_q        <= age_d;
`ifdef LU_CACHE_STATS_EN
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
`endif
    end
  end
  assign req_ready  = state_q == IDLE;
  assign check_addr = check_addr_q;
  assign cell_wen   = cell_wen_q;
  assign cell_waddr = cell_waddr_q;
  assign cell_wdata = cell_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_data   = rsp_data_q;
`ifdef LU_CACHE_STATS_EN
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
`endif
endmodule

// File: tb/tb_lu_cache_ctrl.sv
// tb_lu_cache_ctrl: table-driven check of lu_cache_ctrl lookup, allocation, LRU order and reset abort
module tb_lu_cache_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = '0, req_data = '0;
  logic [7:0]  check_addr, cell_waddr, cell_wdata, rsp_data;
  logic [3:0]  cell_eq = '0, cell_wen;
  logic [31:0] cell_rdata = '0;
  logic        rsp_valid, rsp_hit;
  int          total = 0, bad = 0;
  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [3:0]  eq;
    logic [31:0] rd;
    logic        hit;
    logic [3:0]  wen;
    logic [7:0]  rdo;
  } vec_t;
  vec_t tbl [11];
  logic [3:0] seq4 [5];
  lu_cache_ctrl #(.CELLS(4), .CELL_SIZE(8), .ADDR_SIZE(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .check_addr(check_addr), .cell_eq(cell_eq), .cell_rdata(cell_rdata),
    .cell_wen(cell_wen), .cell_waddr(cell_waddr), .cell_wdata(cell_wdata),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic do_req(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [3:0] eq, input logic [31:0] rd,
                        input logic hit, input logic [3:0] wen, input logic [7:0] rdo);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_wr = wr; req_addr = a; req_data = d; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; cell_eq = eq; cell_rdata = rd;
    chk("lookup_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("lookup_cell_wen", 32'(cell_wen), 32'd0);
    chk("check_addr", 32'(check_addr), 32'(a));
    chk("ready_busy", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    cell_eq = '0; cell_rdata = '0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_hit", 32'(rsp_hit), 32'(hit));
    chk("rsp_data", 32'(rsp_data), 32'(rdo));
    chk("cell_wen", 32'(cell_wen), 32'(wen));
    if (wr) begin
      chk("cell_waddr", 32'(cell_waddr), 32'(a));
      chk("cell_wdata", 32'(cell_wdata), 32'(d));
    end
  endtask
  task automatic finish_req();
    @(posedge clk);
    #1;
    chk("post_cell_wen", 32'(cell_wen), 32'd0);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
  endtask
  initial begin
    tbl[0]  = '{1'b0, 8'h10, 8'h00, 4'b1111, 32'h0,        1'b0, 4'b0000, 8'h00};
    tbl[1]  = '{1'b1, 8'h10, 8'hAA, 4'b0000, 32'h0,        1'b0, 4'b1000, 8'h00};
    tbl[2]  = '{1'b0, 8'h10, 8'h00, 4'b1000, 32'hAA000000, 1'b1, 4'b0000, 8'hAA};
    tbl[3]  = '{1'b1, 8'h20, 8'hBB, 4'b0000, 32'h0,        1'b0, 4'b0100, 8'h00};
    tbl[4]  = '{1'b1, 8'h30, 8'hCC, 4'b0000, 32'h0,        1'b0, 4'b0010, 8'h00};
    tbl[5]  = '{1'b1, 8'h10, 8'hDD, 4'b1000, 32'h0,        1'b1, 4'b1000, 8'h00};
    tbl[6]  = '{1'b0, 8'h40, 8'h00, 4'b0001, 32'h00000077, 1'b0, 4'b0000, 8'h00};
    tbl[7]  = '{1'b1, 8'h40, 8'hEE, 4'b0000, 32'h0,        1'b0, 4'b0001, 8'h00};
    tbl[8]  = '{1'b0, 8'h55, 8'h00, 4'b0110, 32'h00221100, 1'b1, 4'b0000, 8'h11};
    tbl[9]  = '{1'b1, 8'h50, 8'h5A, 4'b0000, 32'h0,        1'b0, 4'b0100, 8'h00};
    tbl[10] = '{1'b0, 8'h66, 8'h00, 4'b0011, 32'h44000033, 1'b1, 4'b0000, 8'h33};
    seq4[0] = 4'b1000; seq4[1] = 4'b0100; seq4[2] = 4'b0010; seq4[3] = 4'b0001; seq4[4] = 4'b1000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_cell_wen", 32'(cell_wen), 32'd0);
    chk("reset_check_addr", 32'(check_addr), 32'd0);
    chk("reset_cell_waddr", 32'(cell_waddr), 32'd0);
    chk("reset_cell_wdata", 32'(cell_wdata), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      do_req(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].eq, tbl[i].rd,
             tbl[i].hit, tbl[i].wen, tbl[i].rdo);
      finish_req();
      repeat (2) @(posedge clk);
      chk("idle_holds_check_addr", 32'(check_addr), 32'(tbl[i].addr));
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, 8'(8'h80 + i), 8'(i), 4'b0000, 32'h0, 1'b0, seq4[i], 8'h00);
      finish_req();
    end
    do_req(1'b1, 8'h90, 8'h99, 4'b0000, 32'h0, 1'b0, 4'b0100, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cell_wen", 32'(cell_wen), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    do_req(1'b0, 8'h90, 8'h00, 4'b1111, 32'hFFFFFFFF, 1'b0, 4'b0000, 8'h00);
    finish_req();
    do_req(1'b1, 8'h91, 8'h42, 4'b0000, 32'h0, 1'b0, 4'b1000, 8'h00);
    finish_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
